// File: rtl/wisc_mem_pkg.sv
// -----------------------------------------------------------------------------
// wisc_mem_pkg
// Shared types and constants for the WISC-S25 main-memory arbitration logic.
//   state_e     : arbiter FSM states (IDLE, WRITE, FILL)
//   owner_e     : which cache owns the current block fill
//   BLOCK_WORDS : words per cache block
//   MEM_LAT     : cycles from read issue to mem_data_valid
//   BLOCK_MASK  : byte-offset bits within a 16-byte block
// -----------------------------------------------------------------------------
package wisc_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2
    } state_e;

    typedef enum logic {
        ICACHE = 1'b0,
        DCACHE = 1'b1
    } owner_e;

    localparam int          BLOCK_WORDS = 8;
    localparam int          MEM_LAT     = 4;
    localparam logic [15:0] BLOCK_MASK  = 16'h000F;

endpackage

// File: rtl/mem_req_prio.sv
// -----------------------------------------------------------------------------
// mem_req_prio
// Combinational fixed-priority picker for the memory arbiter.
// Priority: D-cache store > D-cache miss > I-cache miss. At most one grant.
// Ports:
//   store_req   in  : D-cache write-through store pending
//   dmiss_req   in  : D-cache miss fill pending
//   imiss_req   in  : I-cache miss fill pending
//   grant_store out : store wins
//   grant_dmiss out : D-cache miss wins
//   grant_imiss out : I-cache miss wins
// -----------------------------------------------------------------------------
module mem_req_prio (
    input  logic store_req,
    input  logic dmiss_req,
    input  logic imiss_req,
    output logic grant_store,
    output logic grant_dmiss,
    output logic grant_imiss
);

    assign grant_store = store_req;
    assign grant_dmiss = dmiss_req & ~store_req;
    assign grant_imiss = imiss_req & ~store_req & ~dmiss_req;

endmodule

// File: rtl/mem_fill_arbiter.sv
// -----------------------------------------------------------------------------
// mem_fill_arbiter
// Sequences the single shared main memory between the I-cache and D-cache.
// Services D-cache write-through stores (one write) and block fills for
// either cache (BLOCK_WORDS pipelined reads, fixed-latency returns written
// back word by word into the owning cache).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   icache_miss/icache_addr  : I-cache fill request, held until fill_done
//   dcache_miss/dcache_addr  : D-cache fill request, held until fill_done
//   dcache_wr_req/_addr/_data: D-cache store, held until dcache_wr_ack
//   mem_en/mem_wr/mem_addr/mem_wdata : memory command (addr/wdata 0 when idle)
//   mem_rdata/mem_data_valid : memory read return
//   fill_data/fill_word_idx  : fill word and its index (hold when no write)
//   icache_fill_we/dcache_fill_we     : fill word write strobes
//   icache_fill_done/dcache_fill_done : last-word pulses
//   dcache_wr_ack            : store issued pulse
//   busy                     : arbiter not idle
// -----------------------------------------------------------------------------
module mem_fill_arbiter
    import wisc_mem_pkg::*;
#(
    parameter int  ADDR_W      = 16,
    parameter int  DATA_W      = 16,
    parameter int  BLOCK_WORDS = wisc_mem_pkg::BLOCK_WORDS,
    localparam int IDX_W       = $clog2(BLOCK_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_wr_req,
    input  logic [ADDR_W-1:0] dcache_wr_addr,
    input  logic [DATA_W-1:0] dcache_wr_data,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic [DATA_W-1:0] fill_data,
    output logic [IDX_W-1:0]  fill_word_idx,
    output logic              icache_fill_we,
    output logic              dcache_fill_we,
    output logic              icache_fill_done,
    output logic              dcache_fill_done,
    output logic              dcache_wr_ack,
    output logic              busy
);

    localparam int                CNT_W     = IDX_W + 1;
    localparam logic [CNT_W-1:0]  ISSUE_END = CNT_W'(BLOCK_WORDS);
    localparam logic [IDX_W-1:0]  RET_LAST  = IDX_W'(BLOCK_WORDS - 1);
    localparam logic [ADDR_W-1:0] BASE_MASK = ~ADDR_W'(BLOCK_MASK);

    state_e            state;
    state_e            state_next;
    owner_e            owner;
    logic [CNT_W-1:0]  issue_cnt;
    logic [IDX_W-1:0]  ret_cnt;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] fill_data_q;
    logic [IDX_W-1:0]  fill_idx_q;

    logic grant_store;
    logic grant_dmiss;
    logic grant_imiss;
    logic issue_active;
    logic ret_valid;
    logic ret_last;

    mem_req_prio u_prio (
        .store_req   (dcache_wr_req),
        .dmiss_req   (dcache_miss),
        .imiss_req   (icache_miss),
        .grant_store (grant_store),
        .grant_dmiss (grant_dmiss),
        .grant_imiss (grant_imiss)
    );

    // Returns are only honoured in FILL; a stray valid elsewhere is dropped.
    assign issue_active = (state == FILL) && (issue_cnt < ISSUE_END);
    assign ret_valid    = (state == FILL) && mem_data_valid;
    assign ret_last     = ret_valid && (ret_cnt == RET_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_store) begin
                    state_next = WRITE;
                end else if (grant_dmiss || grant_imiss) begin
                    state_next = FILL;
                end
            end
            WRITE:   state_next = IDLE;
            FILL: begin
                // Fill always runs to its last return; issued reads cannot
                // be cancelled even if the requester drops its miss.
                if (ret_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state: counters, owner, and held fill outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_cnt   <= '0;
            ret_cnt     <= '0;
            owner       <= DCACHE;
            fill_data_q <= '0;
            fill_idx_q  <= '0;
        end else begin
            if (state == IDLE) begin
                issue_cnt <= '0;
                ret_cnt   <= '0;
                if (grant_dmiss) begin
                    owner <= DCACHE;
                end else if (grant_imiss) begin
                    owner <= ICACHE;
                end
            end
            if (issue_active) begin
                issue_cnt <= issue_cnt + CNT_W'(1);
            end
            if (ret_valid) begin
                fill_data_q <= mem_rdata;
                fill_idx_q  <= ret_cnt;
                ret_cnt     <= ret_cnt + IDX_W'(1);
            end
            if (ret_last) begin
                issue_cnt <= '0;
                ret_cnt   <= '0;
            end
        end
    end

    // Request capture: only meaningful while WRITE/FILL use them, so no reset
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (grant_store) begin
                wr_addr <= dcache_wr_addr;
                wr_data <= dcache_wr_data;
            end
            if (grant_dmiss) begin
                base <= dcache_addr & BASE_MASK;
            end else if (grant_imiss) begin
                base <= icache_addr & BASE_MASK;
            end
        end
    end

    // Output logic
    always_comb begin
        mem_en           = 1'b0;
        mem_wr           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        icache_fill_we   = 1'b0;
        dcache_fill_we   = 1'b0;
        icache_fill_done = 1'b0;
        dcache_fill_done = 1'b0;
        dcache_wr_ack    = 1'b0;
        fill_data        = fill_data_q;
        fill_word_idx    = fill_idx_q;
        busy             = (state != IDLE);
        case (state)
            WRITE: begin
                mem_en        = 1'b1;
                mem_wr        = 1'b1;
                mem_addr      = wr_addr;
                mem_wdata     = wr_data;
                dcache_wr_ack = 1'b1;
            end
            FILL: begin
                if (issue_active) begin
                    // Words are two bytes; the block base is aligned so the
                    // offset never carries out of the block.
                    mem_en   = 1'b1;
                    mem_addr = base + ADDR_W'({issue_cnt[IDX_W-1:0], 1'b0});
                end
                if (ret_valid) begin
                    fill_data     = mem_rdata;
                    fill_word_idx = ret_cnt;
                    if (owner == DCACHE) begin
                        dcache_fill_we = 1'b1;
                    end else begin
                        icache_fill_we = 1'b1;
                    end
                end
                if (ret_last) begin
                    if (owner == DCACHE) begin
                        dcache_fill_done = 1'b1;
                    end else begin
                        icache_fill_done = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_fill_arbiter
// Directed bench for mem_fill_arbiter with a fixed-latency memory model.
// Cycle 0 is the IDLE cycle in which a request is presented; expected outputs
// for later cycles follow the documented latency table.
// -----------------------------------------------------------------------------
module tb_mem_fill_arbiter;

    localparam int MEM_LAT = wisc_mem_pkg::MEM_LAT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        icache_miss = 1'b0;
    logic [15:0] icache_addr = '0;
    logic        dcache_miss = 1'b0;
    logic [15:0] dcache_addr = '0;
    logic        dcache_wr_req = 1'b0;
    logic [15:0] dcache_wr_addr = '0;
    logic [15:0] dcache_wr_data = '0;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word_idx;
    logic        icache_fill_we;
    logic        dcache_fill_we;
    logic        icache_fill_done;
    logic        dcache_fill_done;
    logic        dcache_wr_ack;
    logic        busy;

    logic        spur_valid = 1'b0;
    logic [15:0] spur_data = '0;

    always #5 clk = ~clk;

    mem_fill_arbiter #(
        .ADDR_W      (16),
        .DATA_W      (16),
        .BLOCK_WORDS (8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .icache_miss      (icache_miss),
        .icache_addr      (icache_addr),
        .dcache_miss      (dcache_miss),
        .dcache_addr      (dcache_addr),
        .dcache_wr_req    (dcache_wr_req),
        .dcache_wr_addr   (dcache_wr_addr),
        .dcache_wr_data   (dcache_wr_data),
        .mem_en           (mem_en),
        .mem_wr           (mem_wr),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_data_valid   (mem_data_valid),
        .fill_data        (fill_data),
        .fill_word_idx    (fill_word_idx),
        .icache_fill_we   (icache_fill_we),
        .dcache_fill_we   (dcache_fill_we),
        .icache_fill_done (icache_fill_done),
        .dcache_fill_done (dcache_fill_done),
        .dcache_wr_ack    (dcache_wr_ack),
        .busy             (busy)
    );

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory model: a read issued in cycle n returns in cycle n+MEM_LAT.
    logic [MEM_LAT-1:0] mv;
    logic [15:0]        ma [MEM_LAT];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mv <= '0;
            for (int k = 0; k < MEM_LAT; k++) ma[k] <= '0;
        end else begin
            mv    <= {mv[MEM_LAT-2:0], mem_en & ~mem_wr};
            ma[0] <= mem_addr;
            for (int k = 1; k < MEM_LAT; k++) ma[k] <= ma[k-1];
        end
    end

    assign mem_data_valid = mv[MEM_LAT-1] | spur_valid;
    assign mem_rdata      = spur_valid ? spur_data : mem_word(ma[MEM_LAT-1]);

    int n_assert = 0;
    int n_fail   = 0;

    logic        e_en, e_wr, e_iwe, e_dwe, e_idone, e_ddone, e_ack, e_busy;
    logic [15:0] e_addr, e_wdata;
    logic [15:0] e_fdata = '0;
    logic [2:0]  e_idx = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr_exp();
        e_en = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
        e_iwe = 0; e_dwe = 0; e_idone = 0; e_ddone = 0; e_ack = 0; e_busy = 0;
    endtask

    // Fill whose first read issues in cycle s.
    task automatic add_fill(input int c, input int s, input logic [15:0] base, input bit is_d);
        if (c >= s && c <= s + 7) begin
            e_en   = 1;
            e_addr = base + 16'(2 * (c - s));
        end
        if (c >= s + 4 && c <= s + 11) begin
            e_idx   = 3'(c - s - 4);
            e_fdata = mem_word(base + 16'(2 * (c - s - 4)));
            if (is_d) e_dwe = 1; else e_iwe = 1;
        end
        if (c == s + 11) begin
            if (is_d) e_ddone = 1; else e_idone = 1;
        end
        if (c >= s && c <= s + 11) e_busy = 1;
    endtask

    task automatic add_store(input int c, input int w, input logic [15:0] a, input logic [15:0] d);
        if (c == w) begin
            e_en = 1; e_wr = 1; e_addr = a; e_wdata = d; e_ack = 1; e_busy = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".mem_en"},     32'(mem_en),           32'(e_en));
        chk({tag, ".mem_wr"},     32'(mem_wr),           32'(e_wr));
        chk({tag, ".mem_addr"},   32'(mem_addr),         32'(e_addr));
        chk({tag, ".mem_wdata"},  32'(mem_wdata),        32'(e_wdata));
        chk({tag, ".i_we"},       32'(icache_fill_we),   32'(e_iwe));
        chk({tag, ".d_we"},       32'(dcache_fill_we),   32'(e_dwe));
        chk({tag, ".idx"},        32'(fill_word_idx),    32'(e_idx));
        chk({tag, ".fill_data"},  32'(fill_data),        32'(e_fdata));
        chk({tag, ".i_done"},     32'(icache_fill_done), 32'(e_idone));
        chk({tag, ".d_done"},     32'(dcache_fill_done), 32'(e_ddone));
        chk({tag, ".wr_ack"},     32'(dcache_wr_ack),    32'(e_ack));
        chk({tag, ".busy"},       32'(busy),             32'(e_busy));
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        clr_exp();
        check_all("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        next_cycle();
        clr_exp();
        check_all("post_reset");

        // 1: single I-cache fill, 0x0246 -> block 0x0240
        icache_miss = 1'b1;
        icache_addr = 16'h0246;
        for (int c = 1; c <= 14; c++) begin
            next_cycle();
            if (c == 13) icache_miss = 1'b0;
            #1;
            clr_exp();
            add_fill(c, 1, 16'h0240, 1'b0);
            check_all($sformatf("t1.c%0d", c));
        end

        // 2: simultaneous misses, D-cache first, I-cache issues from cycle 14
        icache_miss = 1'b1;
        icache_addr = 16'h1000;
        dcache_miss = 1'b1;
        dcache_addr = 16'h2008;
        for (int c = 1; c <= 27; c++) begin
            next_cycle();
            if (c == 13) dcache_miss = 1'b0;
            if (c == 26) icache_miss = 1'b0;
            #1;
            clr_exp();
            add_fill(c, 1, 16'h2000, 1'b1);
            add_fill(c, 14, 16'h1000, 1'b0);
            check_all($sformatf("t2.c%0d", c));
        end

        // 3: store beats I-cache miss; stray valid during WRITE is ignored
        dcache_wr_req  = 1'b1;
        dcache_wr_addr = 16'h3002;
        dcache_wr_data = 16'hBEEF;
        icache_miss    = 1'b1;
        icache_addr    = 16'h0440;
        for (int c = 1; c <= 16; c++) begin
            next_cycle();
            if (c == 1) begin
                spur_valid = 1'b1;
                spur_data  = 16'hDEAD;
            end
            if (c == 2) begin
                spur_valid    = 1'b0;
                dcache_wr_req = 1'b0;
            end
            if (c == 15) icache_miss = 1'b0;
            #1;
            clr_exp();
            add_store(c, 1, 16'h3002, 16'hBEEF);
            add_fill(c, 3, 16'h0440, 1'b0);
            check_all($sformatf("t3.c%0d", c));
        end

        // 4: D-cache miss dropped after cycle 2, fill still completes
        dcache_miss = 1'b1;
        dcache_addr = 16'h5018;
        for (int c = 1; c <= 13; c++) begin
            next_cycle();
            if (c == 3) dcache_miss = 1'b0;
            #1;
            clr_exp();
            add_fill(c, 1, 16'h5010, 1'b1);
            check_all($sformatf("t4.c%0d", c));
        end

        // 5: reset on cycle 6 of a fill, then a fresh fill restarts at idx 0
        icache_miss = 1'b1;
        icache_addr = 16'h6004;
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            #1;
            clr_exp();
            add_fill(c, 1, 16'h6000, 1'b0);
            check_all($sformatf("t5.c%0d", c));
        end
        next_cycle();
        rst = 1'b1;
        icache_miss = 1'b0;
        #1;
        clr_exp();
        e_idx   = '0;
        e_fdata = '0;
        check_all("t5.rst_async");
        next_cycle();
        check_all("t5.rst_hold");
        rst = 1'b0;
        next_cycle();
        icache_miss = 1'b1;
        icache_addr = 16'h7030;
        for (int c = 1; c <= 13; c++) begin
            next_cycle();
            if (c == 13) icache_miss = 1'b0;
            #1;
            clr_exp();
            add_fill(c, 1, 16'h7030, 1'b0);
            check_all($sformatf("t5r.c%0d", c));
        end

        // 6: stray valid while IDLE, then a fill proving counters untouched
        for (int c = 0; c < 2; c++) begin
            next_cycle();
            spur_valid = 1'b1;
            spur_data  = 16'hDEAD;
            #1;
            clr_exp();
            check_all($sformatf("t6.spur%0d", c));
        end
        next_cycle();
        spur_valid  = 1'b0;
        icache_miss = 1'b1;
        icache_addr = 16'h0800;
        for (int c = 1; c <= 13; c++) begin
            next_cycle();
            if (c == 13) icache_miss = 1'b0;
            #1;
            clr_exp();
            add_fill(c, 1, 16'h0800, 1'b0);
            check_all($sformatf("t6.c%0d", c));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
